k423_if_queue_stage: RTL



---
 rtl/k423_if_pkg.sv | 27 ++
 rtl/k423_sync_fifo.sv | 70 +++++++
 rtl/k423_if_queue_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/k423_if_pkg.sv
// k423 instruction-fetch package: core width macros (defaulted here when the
// build does not supply them), the fetch-queue entry type and fetch constants.
`ifndef CORE_ADDR_W
`define CORE_ADDR_W 32
`endif
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
`ifndef CORE_FETCH_W
`define CORE_FETCH_W 32
`endif
`ifndef CORE_INST_W
`define CORE_INST_W 32
`endif

package k423_if_pkg;

  localparam int unsigned PC_INC = 4;

  localparam logic [`CORE_ADDR_W-1:0] RST_PC_DEFAULT = `CORE_ADDR_W'(32'h8000_0000);

  typedef struct packed {
    logic [`CORE_ADDR_W-1:0] pc;
    logic [`CORE_INST_W-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/k423_sync_fifo.sv
// Synchronous FIFO with flush.
// Ports: clk_i/rst_n_i (sync active-low reset), flush_i empties the FIFO,
// push_i/wdata_i write, pop_i/rdata_o read (rdata_o shows the head),
// full_o/empty_o/count_o status. Push and pop together are allowed when full;
// flush takes priority over push and pop.
module k423_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) wptr_d = ptr_inc(wptr_q);
      if (pop_i)  rptr_d = ptr_inc(rptr_q);
      cnt_d = cnt_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; it is only observed through a nonzero count.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/k423_if_queue_stage.sv
// k423 instruction-fetch stage with multiple outstanding memory requests and a
// fetch queue toward ID.
// Ports: clk_i/rst_n_i (sync active-low reset); pcu_stall_loaduse_i blocks new
// requests; pcu_flush_br_i flushes queue and in-flight fetches; wb_bju_br_*
// redirect PC on flush; if_mem_req_* / if_mem_rsp_* in-order memory interface;
// if_stage_vld_o/id_stage_rdy_i/if_pc_o/if_inst_o present the queue head to ID.
// Optional macro K423_IF_BYPASS_EN: present a response straight to ID when the
// queue is empty (zero-cycle fetch-to-ID latency).
module k423_if_queue_stage
  import k423_if_pkg::*;
#(
  parameter int unsigned             OUTSTD_N = 2,
  parameter int unsigned             FQ_DEPTH = 4,
  parameter logic [`CORE_ADDR_W-1:0] RST_PC   = RST_PC_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     pcu_stall_loaduse_i,
  input  logic                     pcu_flush_br_i,
  output logic                     if_stage_vld_o,
  input  logic                     id_stage_rdy_i,
  input  logic                     wb_bju_br_tkn_i,
  input  logic [`CORE_XLEN-1:0]    wb_bju_br_pc_i,
  output logic                     if_mem_req_vld_o,
  output logic                     if_mem_req_wen_o,
  output logic [`CORE_ADDR_W-1:0]  if_mem_req_addr_o,
  output logic [`CORE_XLEN-1:0]    if_mem_req_wdata_o,
  input  logic                     if_mem_req_rdy_i,
  input  logic                     if_mem_rsp_vld_i,
  input  logic [`CORE_FETCH_W-1:0] if_mem_rsp_rdata_i,
  output logic [`CORE_ADDR_W-1:0]  if_pc_o,
  output logic [`CORE_INST_W-1:0]  if_inst_o
);

  localparam int unsigned InfW   = $clog2(OUTSTD_N + 1);
  localparam int unsigned FqCntW = $clog2(FQ_DEPTH + 1);

  logic [`CORE_ADDR_W-1:0] pc_q, pc_d;
  logic [InfW-1:0]         inflight_q, inflight_d;
  logic [InfW-1:0]         discard_q, discard_d;

  logic                    req_vld, req_hs, rsp_live, byp_vld;
  logic                    fq_push, fq_pop, fq_empty, fq_full;
  logic [FqCntW-1:0]       fq_cnt;
  fq_entry_t               fq_wdata, fq_head;
  logic [`CORE_ADDR_W-1:0] tag_pc;
  logic                    tag_full, tag_empty;
  logic [InfW-1:0]         tag_cnt;

  // Credit check guarantees every in-flight response a queue slot.
  assign req_vld = rst_n_i & ~pcu_stall_loaduse_i & ~pcu_flush_br_i
                 & (32'(inflight_q) < OUTSTD_N)
                 & ((32'(inflight_q) + 32'(fq_cnt)) < FQ_DEPTH);
  assign req_hs   = req_vld & if_mem_req_rdy_i;
  assign rsp_live = if_mem_rsp_vld_i & (discard_q == '0);

`ifdef K423_IF_BYPASS_EN
  assign byp_vld = fq_empty & rsp_live & ~pcu_flush_br_i;
`else
  assign byp_vld = 1'b0;
`endif

  assign fq_wdata.pc   = tag_pc;
  assign fq_wdata.inst = if_mem_rsp_rdata_i[`CORE_INST_W-1:0];
  // A bypassed response that ID takes this cycle never enters the queue.
  assign fq_push = rsp_live & ~pcu_flush_br_i & ~(byp_vld & id_stage_rdy_i);
  assign fq_pop  = ~fq_empty & ~pcu_flush_br_i & id_stage_rdy_i;

  always_comb begin
    if_stage_vld_o = 1'b0;
    if_pc_o        = '0;
    if_inst_o      = '0;
    if (!fq_empty && !pcu_flush_br_i) begin
      if_stage_vld_o = 1'b1;
      if_pc_o        = fq_head.pc;
      if_inst_o      = fq_head.inst;
    end else if (byp_vld) begin
      if_stage_vld_o = 1'b1;
      if_pc_o        = fq_wdata.pc;
      if_inst_o      = fq_wdata.inst;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + InfW'(req_hs) - InfW'(if_mem_rsp_vld_i);
    discard_d  = discard_q;
    if (pcu_flush_br_i) begin
      // Everything still outstanding after this cycle's response is stale.
      discard_d = inflight_q - InfW'(if_mem_rsp_vld_i);
      if (wb_bju_br_tkn_i) pc_d = wb_bju_br_pc_i[`CORE_ADDR_W-1:0];
    end else begin
      if (if_mem_rsp_vld_i && discard_q != '0) discard_d = discard_q - 1'b1;
      if (req_hs) pc_d = pc_q + `CORE_ADDR_W'(PC_INC);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc_q       <= RST_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  k423_sync_fifo #(
    .Width ($bits(fq_entry_t)),
    .Depth (FQ_DEPTH)
  ) u_fetch_queue (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (pcu_flush_br_i),
    .push_i  (fq_push),
    .wdata_i (fq_wdata),
    .pop_i   (fq_pop),
    .rdata_o (fq_head),
    .full_o  (fq_full),
    .empty_o (fq_empty),
    .count_o (fq_cnt)
  );

  // Tags are never flushed: stale responses still pop their tag.
  k423_sync_fifo #(
    .Width (`CORE_ADDR_W),
    .Depth (OUTSTD_N)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (1'b0),
    .push_i  (req_hs),
    .wdata_i (pc_q),
    .pop_i   (if_mem_rsp_vld_i),
    .rdata_o (tag_pc),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_cnt)
  );

  logic unused_fifo_status;
  assign unused_fifo_status = ^{fq_full, tag_full, tag_empty, tag_cnt};

  assign if_mem_req_vld_o   = req_vld;
  assign if_mem_req_wen_o   = 1'b0;
  assign if_mem_req_addr_o  = pc_q;
  assign if_mem_req_wdata_o = '0;

endmodule
